// File: rtl/systolic_west_skew_feeder.sv
// West-edge operand feeder for the systolic PE grid: accepts one activation vector per
// beat, skews lane i by i cycles, frames each job with accum_reset and done.
module systolic_west_skew_feeder #(
   parameter int DATA_WIDTH = 8,
   parameter int ARRAY_DIM  = 4,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic [LEN_WIDTH-1:0]            k_len,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [ARRAY_DIM*DATA_WIDTH-1:0] in_data,
   output logic [ARRAY_DIM*DATA_WIDTH-1:0] out_data,
   output logic [ARRAY_DIM-1:0]            out_valid,
   output logic                            accum_reset,
   output logic                            busy,
   output logic                            done
);

   localparam int FLUSH_W = $clog2(ARRAY_DIM + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_STREAM,
      S_FLUSH,
      S_DONE
   } state_e;

   state_e               state_q, state_d;
   logic [LEN_WIDTH-1:0] remain_q, remain_d;
   logic [FLUSH_W-1:0]   flush_cnt_q, flush_cnt_d;
   logic                 accum_reset_q, accum_reset_d;
   logic                 done_q, done_d;
   logic                 accept;

   assign in_ready    = (state_q == S_STREAM);
   assign accept      = in_valid && in_ready;
   assign busy        = (state_q != S_IDLE);
   assign accum_reset = accum_reset_q;
   assign done        = done_q;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_d     = state_q;
      remain_d    = remain_q;
      flush_cnt_d = flush_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (k_len != '0) begin
                  state_d  = S_CLEAR;
                  remain_d = k_len;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_CLEAR: state_d = S_STREAM;
         S_STREAM: begin
            if (accept) begin
               remain_d = remain_q - LEN_WIDTH'(1);
               if (remain_q == LEN_WIDTH'(1)) begin
                  state_d     = S_FLUSH;
                  flush_cnt_d = '0;
               end
            end
         end
         S_FLUSH: begin
            // Enough bubbles for the deepest lane to drain before done is raised.
            if (flush_cnt_q == FLUSH_W'(ARRAY_DIM - 1)) begin
               state_d = S_DONE;
            end else begin
               flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      accum_reset_d = (state_d == S_CLEAR);
      done_d        = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         remain_q      <= '0;
         flush_cnt_q   <= '0;
         accum_reset_q <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
         state_q       <= state_d;
         remain_q      <= remain_d;
         flush_cnt_q   <= flush_cnt_d;
         accum_reset_q <= accum_reset_d;
         done_q        <= done_d;
      end
   end

   // Lane i is a chain of i+1 registers; the last stage drives PE row i directly.
   for (genvar i = 0; i < ARRAY_DIM; i++) begin : g_lane
      logic [DATA_WIDTH-1:0] data_q  [i+1];
      logic [DATA_WIDTH-1:0] data_d  [i+1];
      logic                  valid_q [i+1];
      logic                  valid_d [i+1];

      always_comb begin
         data_d[0]  = accept ? in_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
         valid_d[0] = accept;
         for (int j = 1; j <= i; j++) begin
            data_d[j]  = data_q[j-1];
            valid_d[j] = valid_q[j-1];
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            // NOTE: the skew line is reset so an aborted job can never leak operands into the next one.
            for (int j = 0; j <= i; j++) begin
               data_q[j]  <= '0;
               valid_q[j] <= 1'b0;
            end
         end else begin
            for (int j = 0; j <= i; j++) begin
               data_q[j]  <= data_d[j];
               valid_q[j] <= valid_d[j];
            end
         end
      end

      assign out_data[i*DATA_WIDTH +: DATA_WIDTH] = data_q[i];
      assign out_valid[i]                         = valid_q[i];
   end

endmodule

// File: tb/tb_systolic_west_skew_feeder.sv
// Directed bench for systolic_west_skew_feeder: skew timing, stalls, edge cases, async
// reset and a behavioural 4x4 PE grid driven by the feeder.
module tb_systolic_west_skew_feeder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] k_len;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [31:0] out_data;
   logic [3:0]  out_valid;
   logic        accum_reset;
   logic        busy;
   logic        done;

   int checks   = 0;
   int failures = 0;

   logic [31:0] job_vec  [4];
   int          acc_step [4];

   logic [7:0] a_m    [4][4];
   logic [7:0] bw     [4][4];
   logic [7:0] pe_acc [4][4];
   int         pe_idx [4];

   systolic_west_skew_feeder #(
      .DATA_WIDTH (8),
      .ARRAY_DIM  (4),
      .LEN_WIDTH  (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .k_len       (k_len),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .accum_reset (accum_reset),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   // Behavioural PE grid: row r multiplies its k-th valid operand with weight bw[k][c].
   always @(posedge clk) begin
      if (accum_reset) begin
         for (int r = 0; r < 4; r++) begin
            pe_idx[r] <= 0;
            for (int c = 0; c < 4; c++) pe_acc[r][c] <= 8'h00;
         end
      end else begin
         for (int r = 0; r < 4; r++) begin
            if (out_valid[r] && pe_idx[r] < 4) begin
               for (int c = 0; c < 4; c++)
                  pe_acc[r][c] <= pe_acc[r][c] + out_data[r*8 +: 8] * bw[pe_idx[r]][c];
               pe_idx[r] <= pe_idx[r] + 1;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Steps are numbered from the cycle in which start is driven; expectations come from
   // the hand-written accept steps, accum_reset step and done step of each job.
   task automatic run_job(input string tag, input logic [15:0] klen, input int nsteps,
                          input logic [31:0] vmask, input int nb, input int clr_step,
                          input int done_step, input int restart_step);
      logic [3:0]  ev;
      logic [31:0] ed;
      int          last_acc;
      int          nxt;
      last_acc = (nb > 0) ? acc_step[nb-1] : -1;
      for (int s = 0; s < nsteps; s++) begin
         ev = '0;
         ed = '0;
         for (int k = 0; k < nb; k++)
            for (int i = 0; i < 4; i++)
               if (acc_step[k] + 1 + i == s) begin
                  ev[i]        = 1'b1;
                  ed[i*8 +: 8] = job_vec[k][i*8 +: 8];
               end
         check($sformatf("%s.valid@%0d", tag, s), out_valid, ev);
         check($sformatf("%s.data@%0d", tag, s), out_data, ed);
         check($sformatf("%s.accum_reset@%0d", tag, s), accum_reset, s == clr_step);
         check($sformatf("%s.done@%0d", tag, s), done, s == done_step);
         check($sformatf("%s.busy@%0d", tag, s), busy, (s >= 1) && (s <= done_step));
         check($sformatf("%s.ready@%0d", tag, s), in_ready,
               (clr_step >= 0) && (s > clr_step) && (s <= last_acc));
         nxt = 0;
         for (int k = 0; k < nb; k++) if (acc_step[k] < s) nxt++;
         start    = (s == 0) || (s == restart_step);
         k_len    = (s == restart_step) ? 16'd7 : klen;
         in_valid = vmask[s];
         in_data  = (nxt < nb) ? job_vec[nxt] : 32'hDEAD_BEEF;
         step();
      end
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   task automatic sys_job(input string tag);
      logic [7:0] e;
      int         beats;
      bit         seen;
      bit         took;
      beats = 0;
      seen  = 1'b0;
      for (int k = 0; k < 4; k++)
         for (int j = 0; j < 4; j++) begin
            a_m[k][j] = 8'($urandom_range(0, 255));
            bw[k][j]  = 8'($urandom_range(0, 255));
         end
      start    = 1'b1;
      k_len    = 16'd4;
      in_valid = 1'b1;
      in_data  = {a_m[0][3], a_m[0][2], a_m[0][1], a_m[0][0]};
      for (int s = 0; s < 40; s++) begin
         took = in_ready && in_valid;
         step();
         start = 1'b0;
         if (took) beats++;
         in_valid = (beats < 4);
         in_data  = (beats < 4) ? {a_m[beats][3], a_m[beats][2], a_m[beats][1], a_m[beats][0]} : '0;
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      in_valid = 1'b0;
      check({tag, ".done_seen"}, seen, 1'b1);
      check({tag, ".beats"}, beats, 4);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            e = 8'h00;
            for (int k = 0; k < 4; k++) e = e + a_m[k][r] * bw[k][c];
            check($sformatf("%s.pe[%0d][%0d]", tag, r, c), pe_acc[r][c], e);
         end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int r = 0; r < 4; r++) pe_idx[r] = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      k_len    = '0;
      in_valid = 1'b0;
      in_data  = '0;
      #11;
      check("rst.out_valid", out_valid, 4'h0);
      check("rst.out_data", out_data, 32'h0);
      check("rst.busy", busy, 1'b0);
      check("rst.in_ready", in_ready, 1'b0);
      check("rst.accum_reset", accum_reset, 1'b0);
      check("rst.done", done, 1'b0);
      #1 rst_n = 1'b1;
      step();

      // Single vector: lane i of 44332211 appears i+1 cycles after acceptance; in_valid
      // held high through CLEAR and FLUSH must not inject beats.
      job_vec[0] = 32'h4433_2211;
      acc_step[0] = 2;
      run_job("t2", 16'd1, 10, 32'h0000_003E, 1, 1, 7, -1);

      // Three contiguous beats.
      job_vec[0] = 32'h3121_1101;
      job_vec[1] = 32'h3222_1202;
      job_vec[2] = 32'h3323_1303;
      acc_step[0] = 2; acc_step[1] = 3; acc_step[2] = 4;
      run_job("t3", 16'd3, 12, 32'h0000_001E, 3, 1, 9, -1);

      // Two-cycle upstream stall between beats 1 and 2.
      acc_step[0] = 2; acc_step[1] = 5; acc_step[2] = 6;
      run_job("t4", 16'd3, 13, 32'h0000_0064, 3, 1, 11, -1);

      // Empty job: straight to done, nothing on the array, in_valid ignored.
      run_job("t5_zero", 16'd0, 4, 32'h0000_0006, 0, -1, 1, -1);

      // start with a new k_len mid-stream must be ignored: two beats, one done.
      job_vec[0] = 32'h5A4B_3C2D;
      job_vec[1] = 32'h8F7E_6D9C;
      acc_step[0] = 2; acc_step[1] = 3;
      run_job("t5_busy", 16'd2, 12, 32'h0000_003C, 2, 1, 8, 3);

      // Asynchronous reset with lanes in flight.
      job_vec[0] = 32'h3121_1101;
      job_vec[1] = 32'h3222_1202;
      start = 1'b1; k_len = 16'd3; step();
      start = 1'b0; in_valid = 1'b1; in_data = job_vec[0]; step();
      step();
      in_data = job_vec[1]; step();
      check("t1.inflight_valid", out_valid, 4'b0011);
      check("t1.inflight_data", out_data, 32'h0000_1102);
      check("t1.inflight_busy", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("t1.async_valid", out_valid, 4'h0);
      check("t1.async_data", out_data, 32'h0);
      check("t1.async_busy", busy, 1'b0);
      check("t1.async_ready", in_ready, 1'b0);
      check("t1.async_accum_reset", accum_reset, 1'b0);
      check("t1.async_done", done, 1'b0);
      #3 rst_n = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      for (int s = 0; s < 4; s++) begin
         step();
         check($sformatf("t1.post_busy@%0d", s), busy, 1'b0);
         check($sformatf("t1.post_valid@%0d", s), out_valid, 4'h0);
         check($sformatf("t1.post_done@%0d", s), done, 1'b0);
      end

      // Feeder driving the PE grid, second job started the cycle after done.
      sys_job("t6_job1");
      step();
      sys_job("t6_job2");
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
